// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester (p0/p1) and data-memory signals of dmem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface dmem_arbiter_if #(parameter int ADDR_W = 16);
    logic              p0_req;
    logic              p0_we;
    logic [31:0]       p0_addr;
    logic [31:0]       p0_wdata;
    logic              p0_ack;
    logic [31:0]       p0_rdata;
    logic              p0_err;
    logic              p1_req;
    logic              p1_we;
    logic [31:0]       p1_addr;
    logic [31:0]       p1_wdata;
    logic              p1_ack;
    logic [31:0]       p1_rdata;
    logic              p1_err;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_err,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for the single-port data memory with wait states.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise p0 has fixed priority.
module dmem_arbiter #(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [3:0]        count;
    logic              owner;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              any_req;
    logic              gnt1;
    logic              sel_we;
    logic              sel_err;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       off;
    logic              access;
    logic              resp;

    assign any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_RR_EN
    logic last;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last <= 1'b1;
        else if (state == IDLE && any_req)
            last <= gnt1;
    assign gnt1 = bus.p1_req & (~bus.p0_req | ~last);
`else
    assign gnt1 = bus.p1_req & ~bus.p0_req;
`endif

    assign sel_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign off       = sel_addr - BASE_ADDR;
    // Range check done in 64 bits so ADDR_W up to 30 never overflows the shift.
    assign sel_err   = (|sel_addr[1:0]) || (sel_addr < BASE_ADDR) ||
                       ((64'(off) >> 2) >= (64'd1 << ADDR_W));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE:
                    if (any_req) begin
                        owner   <= gnt1;
                        we_q    <= sel_we;
                        wdata_q <= sel_wdata;
                        addr_q  <= off[ADDR_W+1:2];
                        err_q   <= sel_err;
                        rdata_q <= '0;
                        count   <= 4'(WAIT_CYCLES);
                        state   <= sel_err ? RESP : ACCESS;
                    end
                ACCESS:
                    if (count != 4'd0)
                        count <= count - 4'd1;
                    else begin
                        rdata_q <= we_q ? 32'd0 : bus.mem_rdata;
                        state   <= RESP;
                    end
                default:
                    state <= IDLE;
            endcase
        end

    // Outputs decode registered state only, so an async reset drops them at once.
    assign access        = state == ACCESS;
    assign resp          = state == RESP;
    assign bus.p0_ack    = resp & ~owner;
    assign bus.p1_ack    = resp & owner;
    assign bus.p0_rdata  = bus.p0_ack ? rdata_q : 32'd0;
    assign bus.p1_rdata  = bus.p1_ack ? rdata_q : 32'd0;
    assign bus.p0_err    = bus.p0_ack & err_q;
    assign bus.p1_err    = bus.p1_ack & err_q;
    assign bus.mem_rd_en = access & ~we_q;
    assign bus.mem_wr_en = access & we_q & (count == 4'd0);
    assign bus.mem_addr  = access ? addr_q : '0;
    assign bus.mem_wdata = access ? wdata_q : 32'd0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random transactions checked against a transaction-level model.
module tb_dmem_arbiter;
    localparam int          AW    = 8;
    localparam int          W     = 1;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();
    dmem_arbiter_if #(.ADDR_W(AW)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(AW)) bus_b ();

    dmem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W),  .BASE_ADDR(BASE)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    dmem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(0),  .BASE_ADDR(BASE)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    dmem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(15), .BASE_ADDR(BASE)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [31:0] dmem    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] sw_mem  [DEPTH];
    logic        sw_req;
    logic [31:0] sw_addr;

    assign bus.mem_rdata = bus.mem_rd_en ? dmem[bus.mem_addr] : 32'd0;
    always @(posedge clk)
        if (bus.mem_wr_en) dmem[bus.mem_addr] <= bus.mem_wdata;

    assign bus_a.mem_rdata = bus_a.mem_rd_en ? sw_mem[bus_a.mem_addr] : 32'd0;
    assign bus_b.mem_rdata = bus_b.mem_rd_en ? sw_mem[bus_b.mem_addr] : 32'd0;
    assign bus_a.p0_req = sw_req;
    assign bus_a.p0_we = 1'b0;
    assign bus_a.p0_addr = sw_addr;
    assign bus_a.p0_wdata = 32'd0;
    assign bus_a.p1_req = 1'b0;
    assign bus_a.p1_we = 1'b0;
    assign bus_a.p1_addr = 32'd0;
    assign bus_a.p1_wdata = 32'd0;
    assign bus_b.p0_req = sw_req;
    assign bus_b.p0_we = 1'b0;
    assign bus_b.p0_addr = sw_addr;
    assign bus_b.p0_wdata = 32'd0;
    assign bus_b.p1_req = 1'b0;
    assign bus_b.p1_we = 1'b0;
    assign bus_b.p1_addr = 32'd0;
    assign bus_b.p1_wdata = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err, bus.mem_rd_en, bus.mem_wr_en,
                |bus.p0_rdata, |bus.p1_rdata, |bus.mem_addr, |bus.mem_wdata};
    endfunction

    // One transaction from an idle DUT, called #1 after a posedge; returns #1 after a posedge with DUT idle.
    task automatic txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        longint a = longint'(addr);
        bit     exp_err;
        int     idx, lat = 0, rd_n = 0, wr_n = 0;
        bit     other = 0, leak = 0, bad_bus = 0, got_err = 0;
        logic [31:0] exp_rd, got_rd = 32'hx;
        exp_err = (a % 4 != 0) || (a < longint'(BASE)) || ((a - longint'(BASE)) / 4 >= DEPTH);
        idx = exp_err ? 0 : int'((a - longint'(BASE)) / 4);
        exp_rd = (exp_err || we) ? 32'd0 : ref_mem[idx];
        drive(port, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (bus.mem_rd_en) begin
                rd_n++;
                if (bus.mem_addr !== AW'(idx)) bad_bus = 1;
            end
            if (bus.mem_wr_en) begin
                wr_n++;
                if (bus.mem_addr !== AW'(idx) || bus.mem_wdata !== wdata) bad_bus = 1;
            end
            if (!bus.mem_rd_en && !bus.mem_wr_en && !(rd_n > 0 && wr_n == 0 && we) && (|bus.mem_addr || |bus.mem_wdata) && (port ? bus.p1_ack : bus.p0_ack)) bad_bus = 1;
            if (port ? bus.p0_ack : bus.p1_ack) other = 1;
            if (port ? (bus.p0_rdata != 0 || bus.p0_err) : (bus.p1_rdata != 0 || bus.p1_err)) leak = 1;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                lat = c;
                got_rd = port ? bus.p1_rdata : bus.p0_rdata;
                got_err = port ? bus.p1_err : bus.p0_err;
            end else if (port ? (bus.p1_rdata != 0 || bus.p1_err) : (bus.p0_rdata != 0 || bus.p0_err)) leak = 1;
        end
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("ack_latency", lat, exp_err ? 1 : W + 2);
        chk("rdata", got_rd, exp_rd);
        chk("err", got_err, exp_err);
        chk("rd_strobes", rd_n, (exp_err || we) ? 0 : W + 1);
        chk("wr_strobes", wr_n, (!exp_err && we) ? 1 : 0);
        chk("other_port_quiet", {other, leak}, 0);
        chk("mem_bus", bad_bus, 0);
        if (!exp_err && we) ref_mem[idx] = wdata;
        @(posedge clk); #1;
    endtask

    initial begin
        int order[4];
        int n_ack, lat_a, lat_b;
        logic [31:0] d_a, d_b, a;
        bit stray;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        sw_req = 1'b0;
        sw_addr = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            dmem[i] = ref_mem[i];
            sw_mem[i] = $urandom;
        end
        ref_mem[0] = 32'hDEADBEEF;
        dmem[0] = 32'hDEADBEEF;
        #2;
        chk("outs_in_reset", all_outs(), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("outs_after_reset", all_outs(), 0);

        txn(0, 0, 32'h400, 32'd0);
        txn(0, 1, 32'h404, 32'h12345678);
        txn(0, 0, 32'h404, 32'd0);
        txn(1, 0, 32'h402, 32'd0);
        txn(1, 0, 32'h3FC, 32'd0);
        txn(1, 0, BASE + 4 * (DEPTH - 1), 32'd0);
        txn(0, 1, BASE + 4 * DEPTH, 32'h55AA55AA);

        // Contention from a fresh reset so the round-robin pointer is known.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        drive(0, 1, 0, 32'h40C, 0);
        drive(1, 1, 0, 32'h424, 0);
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(posedge clk); #1;
            if (bus.p0_ack || bus.p1_ack) begin
                order[n_ack] = bus.p1_ack ? 1 : 0;
                chk("contend_rdata", bus.p0_rdata | bus.p1_rdata, bus.p1_ack ? ref_mem[9] : ref_mem[3]);
                n_ack++;
            end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("contend_acks", n_ack, 4);
        for (int i = 0; i < 4; i++)
`ifdef DMEM_ARB_RR_EN
            chk("grant_order", order[i], i % 2);
`else
            chk("grant_order", order[i], 0);
`endif

        // Reset in the first ACCESS cycle of a read: strobe must drop without a clock.
        drive(0, 1, 0, 32'h408, 0);
        @(posedge clk); #1;
        chk("abort_rd_active", bus.mem_rd_en, 1);
        rst = 1'b1; #1;
        chk("abort_rd_async", all_outs(), 0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0;
        // Reset in the first ACCESS cycle of a write: no write, no ack.
        drive(0, 1, 1, 32'h404, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        drive(0, 0, 0, 0, 0);
        stray = 0;
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (all_outs() != 0) stray = 1;
        end
        chk("abort_quiet", stray, 0);
        txn(0, 0, 32'h404, 32'd0);
        txn(0, 1, 32'h404, 32'hCAFEF00D);
        txn(0, 0, 32'h404, 32'd0);

        for (int t = 0; t < 60; t++) begin
            int k = $urandom_range(0, 9);
            int idx = $urandom_range(0, DEPTH - 1);
            a = k == 0 ? BASE + 32'(4 * idx) + 32'($urandom_range(1, 3)) :
                k == 1 ? BASE - 32'(4 * $urandom_range(1, 64)) :
                k == 2 ? BASE + 32'(4 * (DEPTH + $urandom_range(0, 100))) :
                         BASE + 32'(4 * idx);
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Wait-state sweep: W=0 and W=15 instances, request dropped after acceptance.
        for (int s = 0; s < 2; s++) begin
            sw_addr = s == 0 ? BASE : BASE + 4 * (DEPTH - 1);
            sw_req = 1'b1;
            lat_a = 0; lat_b = 0; d_a = 32'hx; d_b = 32'hx;
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); #1;
                if (c == 1) sw_req = 1'b0;
                if (bus_a.p0_ack && lat_a == 0) begin lat_a = c; d_a = bus_a.p0_rdata; end
                if (bus_b.p0_ack && lat_b == 0) begin lat_b = c; d_b = bus_b.p0_rdata; end
            end
            chk("w0_latency", lat_a, 2);
            chk("w15_latency", lat_b, 17);
            chk("w0_rdata", d_a, sw_mem[s == 0 ? 0 : DEPTH - 1]);
            chk("w15_rdata", d_b, sw_mem[s == 0 ? 0 : DEPTH - 1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
